// File: rtl/lc3b_types.sv
// Shared types for the LC-3b L1 cache: address field widths and the line format.
package lc3b_types;

    localparam int L1_LINES = 8;

    typedef logic [2:0]   lc3b_l1_index;
    typedef logic [8:0]   lc3b_l1_tag;
    typedef logic [2:0]   lc3b_l1_word;
    typedef logic [127:0] lc3b_l1_line;

endpackage

// File: rtl/l1_cache_ctrl_array.sv
// Per-line storage array with synchronous write and combinational read.
// Used for both the 128-bit data lines and the 9-bit tags.
module array
    import lc3b_types::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             write,
    input  lc3b_l1_index     index,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout
);

    logic [WIDTH-1:0] data_q [L1_LINES];

    always_ff @(posedge clk) begin
        if (write) begin
            data_q[index] <= datain;
        end
    end

    assign dataout = data_q[index];

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-back L1 cache controller: 8 lines of 128 bits, 16-bit CPU words.
// The request address is captured on acceptance so an abandoned request cannot corrupt a fill.
module l1_cache_ctrl
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_e;

    state_e              state_q, state_d;
    logic [L1_LINES-1:0] valid_q, valid_d;
    logic [L1_LINES-1:0] dirty_q, dirty_d;
    logic [15:1]         addr_q, addr_d;

    lc3b_l1_tag   req_tag, stored_tag;
    lc3b_l1_index req_index;
    lc3b_l1_word  req_word;
    lc3b_l1_line  line_out, line_in;
    logic         data_we, tag_we;
    logic         req, hit;
    logic [15:0]  old_word, new_word;
    logic         unused_addr_bit;

    assign req             = mem_read | mem_write;
    assign req_tag         = addr_q[15:7];
    assign req_index       = addr_q[6:4];
    assign req_word        = addr_q[3:1];
    assign unused_addr_bit = mem_address[0];

    assign hit      = valid_q[req_index] && (stored_tag == req_tag);
    assign old_word = line_out[{req_word, 4'b0000} +: 16];
    assign new_word = {mem_byte_enable[1] ? mem_wdata[15:8] : old_word[15:8],
                       mem_byte_enable[0] ? mem_wdata[7:0]  : old_word[7:0]};

    array #(.WIDTH(128)) data_array (
        .clk     (clk),
        .write   (data_we),
        .index   (req_index),
        .datain  (line_in),
        .dataout (line_out)
    );

    array #(.WIDTH(9)) tag_array (
        .clk     (clk),
        .write   (tag_we),
        .index   (req_index),
        .datain  (req_tag),
        .dataout (stored_tag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        addr_d       = addr_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        line_in      = line_out;
        mem_rdata    = '0;
        mem_resp     = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = mem_address[15:1];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    mem_resp = 1'b1;
                    state_d  = IDLE;
                    // A write with no byte lanes enabled still completes but must not dirty the line.
                    if (mem_write) begin
                        if (mem_byte_enable != 2'b00) begin
                            data_we = 1'b1;
                            line_in[{req_word, 4'b0000} +: 16] = new_word;
                            dirty_d[req_index] = 1'b1;
                        end
                    end else begin
                        mem_rdata = old_word;
                    end
                end else if (valid_q[req_index] && dirty_q[req_index]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {stored_tag, req_index, 4'b0000};
                pmem_wdata   = line_out;
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, 4'b0000};
                if (pmem_resp) begin
                    data_we            = 1'b1;
                    tag_we             = 1'b1;
                    line_in            = pmem_rdata;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = 1'b0;
                    // Only re-check if the original request is still being presented.
                    state_d = (req && (mem_address[15:1] == addr_q)) ? CHECK : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
